// File: rtl/mips_pkg.sv
// Shared register-file constants for the integer pipeline.
package mips_pkg;
    localparam int          REG_NUM  = 32;
    localparam int          REG_AW   = 5;
    localparam logic [4:0]  REG_ZERO = 5'd0;
endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter with saturation guard and underflow detect.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic nz,
    output logic full,
    output logic underflow
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign nz        = (cnt_q != '0);
    assign full      = (cnt_q == '1);
    assign underflow = dec & ~nz;

    // Simultaneous inc/dec cancel; a dec at zero is dropped (reported via underflow).
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec && !full) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc && nz) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/rf_scoreboard.sv
// Issue-side RAW/WAW hazard scoreboard: one pending-write counter per GPR (r0 untracked).
module rf_scoreboard
    import mips_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               id_valid,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic               id_rs_used,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic               id_rt_used,
    input  logic               id_we,
    input  logic [REG_AW-1:0]  id_waddr,
    output logic               issue_ready,
    input  logic               wb_valid,
    input  logic [REG_AW-1:0]  wb_waddr,
    input  logic               flush,
    output logic [REG_NUM-1:0] pending,
    output logic               sb_err
);
    logic [REG_NUM-1:0] full_vec;
    logic [REG_NUM-1:0] uflow_vec;
    logic               fire, do_inc, do_ret;
    logic               rs_ok, rt_ok, wr_ok;
    logic               sb_err_q, sb_err_d;

    assign rs_ok       = ~id_rs_used | ~pending[id_rs];
    assign rt_ok       = ~id_rt_used | ~pending[id_rt];
    assign wr_ok       = ~id_we | (id_waddr == REG_ZERO) | ~full_vec[id_waddr];
    assign issue_ready = rs_ok & rt_ok & wr_ok;

    assign fire   = id_valid & issue_ready & ~flush;
    assign do_inc = fire & id_we & (id_waddr != REG_ZERO);
    assign do_ret = wb_valid & ~flush & (wb_waddr != REG_ZERO);

    assign pending[0]   = 1'b0;
    assign full_vec[0]  = 1'b0;
    assign uflow_vec[0] = 1'b0;

    generate
        for (genvar i = 1; i < REG_NUM; i++) begin : g_cnt
            sb_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk       (clk),
                .resetn    (resetn),
                .inc       (do_inc && (id_waddr == REG_AW'(i))),
                .dec       (do_ret && (wb_waddr == REG_AW'(i))),
                .clr       (flush),
                .nz        (pending[i]),
                .full      (full_vec[i]),
                .underflow (uflow_vec[i])
            );
        end
    endgenerate

    // Sticky until flush or reset.
    always_comb begin
        sb_err_d = sb_err_q | (|uflow_vec);
        if (flush) begin
            sb_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sb_err_q <= 1'b0;
        end else begin
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err = sb_err_q;
endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed + randomized bench for rf_scoreboard against a per-register count model.
module tb_rf_scoreboard;
    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        resetn;
    logic        id_valid, id_rs_used, id_rt_used, id_we;
    logic [4:0]  id_rs, id_rt, id_waddr, wb_waddr;
    logic        wb_valid, flush;
    logic        issue_ready, sb_err;
    logic [31:0] pending;

    int tests = 0;
    int fails = 0;
    int cnt[32];
    bit merr;
    logic        last_ready;
    logic [31:0] snap;

    always #5 clk = ~clk;

    rf_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn),
        .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rt(id_rt), .id_rt_used(id_rt_used), .id_we(id_we), .id_waddr(id_waddr),
        .issue_ready(issue_ready), .wb_valid(wb_valid), .wb_waddr(wb_waddr),
        .flush(flush), .pending(pending), .sb_err(sb_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready(int rs, bit rsu, int rt, bit rtu, bit we, int wa);
        bit ok_s, ok_t, ok_w;
        ok_s = !rsu || cnt[rs] == 0;
        ok_t = !rtu || cnt[rt] == 0;
        ok_w = !we || wa == 0 || cnt[wa] < MAXC;
        return ok_s && ok_t && ok_w;
    endfunction

    function automatic logic [31:0] m_pend();
        logic [31:0] p = '0;
        for (int r = 1; r < 32; r++) p[r] = (cnt[r] != 0);
        return p;
    endfunction

    function automatic void m_clear();
        for (int r = 0; r < 32; r++) cnt[r] = 0;
        merr = 1'b0;
    endfunction

    // Drive one cycle of inputs (called just after a rising edge), check, advance model.
    task automatic step(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                        input bit we, input int wa, input bit wbv, input int wba, input bit fl);
        bit rdy, inc, dec;
        id_valid = v;  id_rs = 5'(rs); id_rs_used = rsu; id_rt = 5'(rt); id_rt_used = rtu;
        id_we = we; id_waddr = 5'(wa); wb_valid = wbv; wb_waddr = 5'(wba); flush = fl;
        #1;
        rdy = m_ready(rs, rsu, rt, rtu, we, wa);
        last_ready = issue_ready;
        check("issue_ready", {31'b0, issue_ready}, {31'b0, rdy});
        @(posedge clk);
        if (fl) begin
            m_clear();
        end else begin
            inc = v && rdy && we && wa != 0;
            dec = wbv && wba != 0;
            if (dec) begin
                if (cnt[wba] == 0) merr = 1'b1;
                else if (!(inc && wa == wba)) cnt[wba]--;
            end
            if (inc && !(dec && wa == wba && cnt[wa] == 0) && !(dec && wa == wba))
                cnt[wa]++;
        end
        #1;
        check("pending", pending, m_pend());
        check("sb_err", {31'b0, sb_err}, {31'b0, merr});
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_clear();
        resetn = 1'b0;
        id_valid = 1; id_rs = 5; id_rs_used = 1; id_rt = 6; id_rt_used = 1;
        id_we = 1; id_waddr = 7; wb_valid = 0; wb_waddr = 0; flush = 0;
        #2;
        check("rst_pending", pending, 32'h0);
        check("rst_sb_err", {31'b0, sb_err}, 32'h0);
        check("rst_ready", {31'b0, issue_ready}, 32'h1);
        @(posedge clk); #1;
        resetn = 1'b1;

        // Reset and idle
        step(1, 5, 1, 6, 1, 1, 7, 0, 0, 0);
        check("idle_ready", {31'b0, last_ready}, 32'h1);
        check("idle_pend", pending, 32'h80);

        // RAW stall and release on r7
        step(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
        check("raw_stall", {31'b0, last_ready}, 32'h0);
        step(1, 7, 1, 0, 0, 0, 0, 1, 7, 0);
        check("raw_stall_wb", {31'b0, last_ready}, 32'h0);
        step(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
        check("raw_release", {31'b0, last_ready}, 32'h1);
        check("raw_pend7", {31'b0, pending[7]}, 32'h0);

        // Saturation on r3
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 3, 1, 3, 0);
        check("sat_block", {31'b0, last_ready}, 32'h0);
        step(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        check("sat_restore", {31'b0, last_ready}, 32'h1);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);

        // Simultaneous issue/retire on r9, and register 0
        step(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 9, 1, 9, 0);
        check("sim_pend9", {31'b0, pending[9]}, 32'h1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        check("sim_drain9", {31'b0, pending[9]}, 32'h0);
        step(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        snap = pending;
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        check("r0_waddr", pending, snap);
        step(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        check("r0_src", {31'b0, last_ready}, 32'h1);

        // Underflow then flush
        step(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
        check("uflow_err", {31'b0, sb_err}, 32'h1);
        idle();
        check("uflow_sticky", {31'b0, sb_err}, 32'h1);
        step(1, 0, 0, 0, 0, 1, 4, 0, 0, 1);
        check("flush_pend", pending, 32'h0);
        check("flush_err", {31'b0, sb_err}, 32'h0);

        // Asynchronous reset mid-run
        step(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 8, 1, 5, 0);
        step(1, 0, 0, 0, 0, 1, 8, 0, 0, 0);
        idle();
        #2 resetn = 1'b0;
        #1;
        check("arst_pend", pending, 32'h0);
        check("arst_err", {31'b0, sb_err}, 32'h0);
        m_clear();
        @(posedge clk); #1;
        resetn = 1'b1;

        // Randomized traffic on r0..r7 to concentrate hazards
        for (int n = 0; n < 400; n++) begin
            int rs, rt, wa, wba;
            bit wbv, fl;
            rs  = $urandom_range(0, 7);
            rt  = $urandom_range(0, 7);
            wa  = $urandom_range(0, 7);
            wba = $urandom_range(0, 7);
            wbv = ($urandom_range(0, 1) == 0);
            if (wbv && cnt[wba] == 0 && $urandom_range(0, 9) != 0) wbv = 0;
            fl  = ($urandom_range(0, 39) == 0);
            step($urandom_range(0, 3) != 0, rs, $urandom_range(0, 1), rt, $urandom_range(0, 1),
                 $urandom_range(0, 3) != 0, wa, wbv, wba, fl);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Issue-side hazard tracker paired with the register file: records every in-flight instruction that will write a general-purpose register and withholds issue from the decode stage until all of its source operands have been written back. Sits between decode (issuer) and writeback (retirer). Each register has a pending-write counter: issue increments it and register-file writeback decrements it. The block drives `issue_ready` so that decode never reads a stale operand through the register file's combinational read ports.

## Interface
- `CNT_W`, default 2: width of each pending-write counter. Maximum pending writes per register is 2^CNT_W−1 (3 by default).
- `clk` in 1: rising-edge clock.
- `resetn` in 1: asynchronous, active-low reset.
- `id_valid` in 1: decode holds an instruction requesting issue.
- `id_rs` in 5: source register 1.
- `id_rs_used` in 1: instruction reads `id_rs`.
- `id_rt` in 5: source register 2.
- `id_rt_used` in 1: instruction reads `id_rt`.
- `id_we` in 1: instruction will write a register.
- `id_waddr` in 5: destination register.
- `issue_ready` out 1: issue may proceed this cycle (combinational).
- `wb_valid` in 1: writeback retires a register write this cycle. This is the same cycle the register file's write enable is high.
- `wb_waddr` in 5: register being retired.
- `flush` in 1: synchronous clear of all tracking state.
- `pending` out 32: bit i is high when counter i is nonzero. Bit 0 is always 0.
- `sb_err` out 1: sticky protocol-violation flag.

## Operation
- Issue fires when `id_valid & issue_ready & !flush`.
- `issue_ready` is high only when all three conditions hold:
  - `id_rs_used` is low, or `pending[id_rs]` is low.
  - `id_rt_used` is low, or `pending[id_rt]` is low.
  - `id_we` is low, or `id_waddr` is 0, or counter[`id_waddr`] is below its maximum value.
- `issue_ready` does not depend on `wb_valid`. A retire in cycle t does not unblock a dependent instruction in cycle t.
- When issue fires with `id_we` high and `id_waddr` nonzero, counter[`id_waddr`] increments.
- A retire occurs when `wb_valid & !flush` and `wb_waddr` is nonzero:
  - If counter[`wb_waddr`] is nonzero, it decrements.
  - If counter[`wb_waddr`] is 0, the decrement is dropped and `sb_err` is set.
- Issue and retire to the same register in the same cycle leave its counter unchanged.
- Register 0 is never tracked:
  - Issue and retire targeting register 0 are ignored.
  - A source of register 0 never stalls.
- When `flush` is high, all counters and `sb_err` clear at the next edge. Issue and retire in that cycle have no effect. `issue_ready` may still be high during a flush cycle, but no issue fires.
- Writeback must not retire instructions that were flushed. The pipeline guarantees this.

## Timing
- Reset (`resetn` low, asynchronous): all counters are 0, `pending` is 0 and `sb_err` is 0. Consequently `issue_ready` depends only on the id inputs, so it is high.
- Issue in cycle t: `pending` reflects the new write from cycle t+1.
- Retire in cycle t: the counter updates at edge t→t+1, and a dependent source may issue in cycle t+1. This matches the register file's behaviour, where the write lands at that same edge and the combinational read in t+1 returns the new value.
- `issue_ready` latency: zero cycles from the id inputs, one cycle from state changes.
- Reset asserted mid-operation clears state immediately, regardless of outstanding writebacks.
- No output is X while `resetn` is low.

## Structure
- Shared package `mips_pkg` holds:
  - `REG_NUM = 32` and `REG_AW = 5`.
  - `REG_ZERO = 5'd0`.
- Sub-module `sb_counter`: CNT_W-bit up/down counter.
  - Inputs: `inc`, `dec`, `clr`.
  - Outputs: `nz` (nonzero), `full` (at maximum) and `underflow` (dec requested at zero).
  - Asynchronous active-low reset.
- `rf_scoreboard` instantiates 31 copies of `sb_counter` via generate (indices 1–31) and adds:
  - one-hot decode of `id_waddr` and `wb_waddr`;
  - operand muxing for the `issue_ready` conditions;
  - the `sb_err` register.

## Test plan
- **Reset and idle:** after `resetn` rises, drive `id_valid=1`, `rs=5`, `rt=6`, both used, `we=1`, `waddr=7`. Expect `issue_ready=1`, then `pending=32'h80` on the next cycle.
- **RAW stall and release:** issue a write to r7, then present an instruction reading r7. Expect `issue_ready=0` until `wb_valid` with `wb_waddr=7` at cycle t. Expect `issue_ready=1` at t+1 and `pending[7]=0`.
- **Saturation:** with CNT_W=2, issue three writes to r3. A fourth write to r3 gives `issue_ready=0`. One retire of r3 restores `issue_ready=1` on the next cycle.
- **Simultaneous events and register 0:**
  - With counter[9]=1, issue to r9 and retire r9 in the same cycle: counter stays at 1.
  - Issue with `waddr=0`: `pending` is unchanged.
  - Source r0 with unused dest: never stalls.
- **Underflow and flush:**
  - `wb_valid` with `wb_waddr=12` while counter[12]=0: `sb_err=1` and stays high.
  - `flush=1` together with an issue to r4: next cycle `pending=0`, `sb_err=0`, counter[4]=0.
- **Asynchronous reset mid-run:** with several counters nonzero, pulse `resetn` low between clock edges. Expect `pending=0` immediately, with no clock edge required.
